// File: rtl/cdr_pkg.sv
// cdr_pkg: shared types and constants for the CDR phase loop controller.
//   cdr_state_e : loop state (IDLE / ACQUIRE / TRACK)
//   CNT_D_*     : delay setting driven to the phase detector in each state
//   STEP_*      : phase step applied per correction in each state
//   phase_step(): modulo phase increment/decrement helper
package cdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } cdr_state_e;

    localparam logic [1:0] CNT_D_IDLE  = 2'd0;
    localparam logic [1:0] CNT_D_TRACK = 2'd1;
    localparam logic [1:0] CNT_D_ACQ   = 2'd2;

    localparam logic [5:0] STEP_ACQ    = 6'd2;
    localparam logic [5:0] STEP_TRACK  = 6'd1;

    // Move phase index nb by step in the given direction, wrapping
    // within 0..n_phases-1. Requires step < n_phases.
    function automatic logic [5:0] phase_step(
        input logic [5:0] nb,
        input logic [5:0] step,
        input logic       up,
        input logic [6:0] n_phases
    );
        logic [6:0] w_sum;
        if (up) begin
            w_sum = {1'b0, nb} + {1'b0, step};
            if (w_sum >= n_phases) begin
                w_sum = w_sum - n_phases;
            end
        end else begin
            if (nb < step) begin
                w_sum = {1'b0, nb} + n_phases - {1'b0, step};
            end else begin
                w_sum = {1'b0, nb} - {1'b0, step};
            end
        end
        return w_sum[5:0];
    endfunction

endpackage

// File: rtl/cdr_phase_ctrl_vote_window.sv
// vote_window: collects phase detector votes over VOTE_WIN strobes and
// produces a majority decision on the closing strobe (combinational, same
// cycle as that strobe).
//   i_clk, i_rst (sync, active-low)
//   i_clr   : discard any partial window
//   i_stb   : qualified strobe (already gated by loop activity)
//   i_T,i_E : transition / early flags
//   o_dec   : window closes this cycle
//   o_up    : late majority >= VOTE_TH (increment)
//   o_dn    : early majority >= VOTE_TH (decrement)
module vote_window #(
    parameter int unsigned VOTE_WIN = 8,
    parameter int unsigned VOTE_TH  = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_stb,
    input  logic i_T,
    input  logic i_E,
    output logic o_dec,
    output logic o_up,
    output logic o_dn
);
    import cdr_pkg::*;

    localparam logic [3:0]        LAST_STB = 4'(VOTE_WIN - 1);
    localparam logic signed [4:0] TH_POS   = 5'(VOTE_TH);
    localparam logic signed [4:0] TH_NEG   = -TH_POS;

    logic [3:0]        r_stb_cnt;
    logic [3:0]        r_late;
    logic [3:0]        r_early;
    logic [3:0]        w_late_nx;
    logic [3:0]        w_early_nx;
    logic              w_close;
    logic signed [4:0] w_d;

    // Closing strobe's own vote is folded in before the compare.
    always_comb begin
        w_late_nx  = r_late  + {3'b000, i_T & ~i_E};
        w_early_nx = r_early + {3'b000, i_T &  i_E};
        w_close    = i_stb && (r_stb_cnt == LAST_STB);
        w_d        = $signed({1'b0, w_late_nx}) - $signed({1'b0, w_early_nx});
        o_dec      = w_close;
        o_up       = w_close && (w_d >= TH_POS);
        o_dn       = w_close && (w_d <= TH_NEG);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clr || w_close) begin
            r_stb_cnt <= '0;
            r_late    <= '0;
            r_early   <= '0;
        end else if (i_stb) begin
            r_stb_cnt <= r_stb_cnt + 4'd1;
            r_late    <= w_late_nx;
            r_early   <= w_early_nx;
        end
    end

endmodule

// File: rtl/cdr_phase_ctrl.sv
// cdr_phase_ctrl: CDR loop controller. Majority-filters phase detector
// votes per window, steers the phase select (modulo NB_PHASES) and delay
// setting, and runs the IDLE/ACQUIRE/TRACK lock state machine.
//   i_clk    : work clock
//   i_rst    : synchronous active-low reset
//   i_en     : loop enable (0 forces IDLE, phase retained)
//   i_pd_stb : phase detector strobe, i_T/i_E valid
//   i_T,i_E  : transition / early flags
//   o_nb_P   : phase select
//   o_cnt_d  : delay setting (IDLE=0, ACQ=2, TRACK=1)
//   o_upd    : one-cycle pulse on phase change
//   o_dir    : direction of last update (1 = increment)
//   o_lock   : high in TRACK
module cdr_phase_ctrl #(
    parameter int unsigned NB_PHASES  = 50,
    parameter int unsigned NB_P_INIT  = 0,
    parameter int unsigned VOTE_WIN   = 8,
    parameter int unsigned VOTE_TH    = 2,
    parameter int unsigned LOCK_WIN   = 16,
    parameter int unsigned UNLOCK_WIN = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_pd_stb,
    input  logic       i_T,
    input  logic       i_E,
    output logic [5:0] o_nb_P,
    output logic [1:0] o_cnt_d,
    output logic       o_upd,
    output logic       o_dir,
    output logic       o_lock
);
    import cdr_pkg::*;

    localparam int unsigned QW = $clog2(LOCK_WIN + 1);
    localparam int unsigned UW = $clog2(UNLOCK_WIN + 1);
    localparam logic [QW-1:0] QUIET_LAST  = QW'(LOCK_WIN - 1);
    localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_WIN - 1);

    cdr_state_e    r_state, w_state_nx;
    logic [5:0]    r_nb_p, w_nb_p_nx;
    logic [1:0]    r_cnt_d, w_cnt_d_nx;
    logic          r_upd, w_upd_nx;
    logic          r_dir, w_dir_nx;
    logic [QW-1:0] r_quiet, w_quiet_nx;
    logic [UW-1:0] r_unlock, w_unlock_nx;
    logic [5:0]    w_step;
    logic          w_stb, w_clr, w_dec, w_up, w_dn, w_corr;

    // Strobes are dropped while idle or in the cycle the loop is disabled.
    assign w_stb  = i_pd_stb && i_en && (r_state != ST_IDLE);
    assign w_clr  = !i_en || (r_state == ST_IDLE);
    assign w_corr = w_up || w_dn;

    vote_window #(
        .VOTE_WIN (VOTE_WIN),
        .VOTE_TH  (VOTE_TH)
    ) u_vote (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_clr),
        .i_stb (w_stb),
        .i_T   (i_T),
        .i_E   (i_E),
        .o_dec (w_dec),
        .o_up  (w_up),
        .o_dn  (w_dn)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state  <= ST_IDLE;
            r_nb_p   <= 6'(NB_P_INIT);
            r_cnt_d  <= CNT_D_IDLE;
            r_upd    <= 1'b0;
            r_dir    <= 1'b0;
            r_quiet  <= '0;
            r_unlock <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_nb_p   <= w_nb_p_nx;
            r_cnt_d  <= w_cnt_d_nx;
            r_upd    <= w_upd_nx;
            r_dir    <= w_dir_nx;
            r_quiet  <= w_quiet_nx;
            r_unlock <= w_unlock_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_nb_p_nx   = r_nb_p;
        w_dir_nx    = r_dir;
        w_upd_nx    = 1'b0;
        w_quiet_nx  = r_quiet;
        w_unlock_nx = r_unlock;
        w_cnt_d_nx  = CNT_D_IDLE;
        w_step      = (r_state == ST_TRACK) ? STEP_TRACK : STEP_ACQ;

        if (!i_en) begin
            w_state_nx  = ST_IDLE;
            w_quiet_nx  = '0;
            w_unlock_nx = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx  = ST_ACQ;
                    w_quiet_nx  = '0;
                    w_unlock_nx = '0;
                end
                ST_ACQ: begin
                    if (w_dec) begin
                        if (w_corr) begin
                            w_quiet_nx = '0;
                        end else if (r_quiet == QUIET_LAST) begin
                            w_state_nx  = ST_TRACK;
                            w_quiet_nx  = '0;
                            w_unlock_nx = '0;
                        end else begin
                            w_quiet_nx = r_quiet + 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    // Direction compare uses the previous update's r_dir.
                    if (w_dec) begin
                        if (!w_corr || (w_up != r_dir)) begin
                            w_unlock_nx = '0;
                        end else if (r_unlock == UNLOCK_LAST) begin
                            w_state_nx  = ST_ACQ;
                            w_quiet_nx  = '0;
                            w_unlock_nx = '0;
                        end else begin
                            w_unlock_nx = r_unlock + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end

        // Exit from TRACK still applies this correction with the TRACK step.
        if (w_dec && w_corr) begin
            w_nb_p_nx = phase_step(r_nb_p, w_step, w_up, 7'(NB_PHASES));
            w_dir_nx  = w_up;
            w_upd_nx  = 1'b1;
        end

        case (w_state_nx)
            ST_ACQ:   w_cnt_d_nx = CNT_D_ACQ;
            ST_TRACK: w_cnt_d_nx = CNT_D_TRACK;
            default:  w_cnt_d_nx = CNT_D_IDLE;
        endcase
    end

    assign o_nb_P  = r_nb_p;
    assign o_cnt_d = r_cnt_d;
    assign o_upd   = r_upd;
    assign o_dir   = r_dir;
    assign o_lock  = (r_state == ST_TRACK);

endmodule

// File: tb/tb_cdr_phase_ctrl.sv
// tb_cdr_phase_ctrl: directed stimulus for cdr_phase_ctrl with a
// behavioural reference model compared every cycle, plus literal
// expectations at the key points of each scenario.
module tb_cdr_phase_ctrl;

    localparam int NPH = 50;
    localparam int VW  = 8;
    localparam int TH  = 2;
    localparam int LW  = 16;
    localparam int UW  = 4;

    logic       clk = 1'b0;
    logic       rst, en, stb, t, e;
    logic [5:0] nb_p;
    logic [1:0] cnt_d;
    logic       upd, dir, lock;

    int tests = 0;
    int fails = 0;

    cdr_phase_ctrl #(
        .NB_PHASES  (NPH),
        .NB_P_INIT  (0),
        .VOTE_WIN   (VW),
        .VOTE_TH    (TH),
        .LOCK_WIN   (LW),
        .UNLOCK_WIN (UW)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
        .i_pd_stb (stb),
        .i_T      (t),
        .i_E      (e),
        .o_nb_P   (nb_p),
        .o_cnt_d  (cnt_d),
        .o_upd    (upd),
        .o_dir    (dir),
        .o_lock   (lock)
    );

    always #10 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: mode 0 = idle, 1 = acquiring, 2 = locked.
    int m_mode = 0, m_nb = 0, m_dir = 0, m_upd = 0;
    int m_nstb = 0, m_late = 0, m_early = 0, m_quiet = 0, m_same = 0;

    always @(posedge clk) begin
        int d, corr, step;
        m_upd = 0;
        if (!rst) begin
            m_mode = 0; m_nb = 0; m_dir = 0;
            m_nstb = 0; m_late = 0; m_early = 0; m_quiet = 0; m_same = 0;
        end else if (!en) begin
            m_mode = 0;
            m_nstb = 0; m_late = 0; m_early = 0; m_quiet = 0; m_same = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_nstb = 0; m_late = 0; m_early = 0; m_quiet = 0; m_same = 0;
        end else if (stb) begin
            m_nstb++;
            if (t && e) m_early++;
            else if (t) m_late++;
            if (m_nstb == VW) begin
                d    = m_late - m_early;
                step = (m_mode == 2) ? 1 : 2;
                corr = (d >= TH) ? 1 : ((d <= -TH) ? -1 : 0);
                if (corr != 0) begin
                    m_nb  = (m_nb + corr * step + NPH) % NPH;
                    m_upd = 1;
                    if (m_mode == 1) begin
                        m_quiet = 0;
                    end else begin
                        m_same = (((corr > 0) ? 1 : 0) == m_dir) ? m_same + 1 : 0;
                        if (m_same == UW) begin
                            m_mode = 1; m_same = 0; m_quiet = 0;
                        end
                    end
                    m_dir = (corr > 0) ? 1 : 0;
                end else begin
                    if (m_mode == 1) begin
                        m_quiet++;
                        if (m_quiet == LW) begin
                            m_mode = 2; m_quiet = 0; m_same = 0;
                        end
                    end else begin
                        m_same = 0;
                    end
                end
                m_nstb = 0; m_late = 0; m_early = 0;
            end
        end
        #1;
        check("m_nb",    nb_p,  m_nb);
        check("m_cnt_d", cnt_d, (m_mode == 0) ? 0 : ((m_mode == 1) ? 2 : 1));
        check("m_upd",   upd,   m_upd);
        check("m_dir",   dir,   m_dir);
        check("m_lock",  lock,  (m_mode == 2) ? 1 : 0);
    end

    // Back-to-back strobes: nl late, ne early, nz no-transition; returns at
    // the negedge after the closing edge.
    task automatic window(input int nl, input int ne, input int nz);
        for (int i = 0; i < nl; i++) begin @(negedge clk); stb = 1; t = 1; e = 0; end
        for (int i = 0; i < ne; i++) begin @(negedge clk); stb = 1; t = 1; e = 1; end
        for (int i = 0; i < nz; i++) begin @(negedge clk); stb = 1; t = 0; e = 0; end
        @(negedge clk); stb = 0; t = 0; e = 0;
    endtask

    task automatic corr(input int up);
        if (up != 0) window(8, 0, 0);
        else         window(0, 8, 0);
    endtask

    int trk_dir [11] = '{1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};
    int trk_nb  [11] = '{49, 0, 49, 0, 1, 2, 3, 2, 3, 4, 3};
    int dn_nb   [3]  = '{2, 1, 0};

    initial begin
        rst = 0; en = 1; stb = 0; t = 0; e = 0;

        // 1: reset dominates live strobes, then first late window
        repeat (6) begin @(negedge clk); stb = ~stb; t = 1; end
        @(negedge clk); stb = 0;
        check("rst_nb", nb_p, 0);
        check("rst_cnt_d", cnt_d, 0);
        check("rst_lock", lock, 0);
        check("rst_upd", upd, 0);
        rst = 1;
        @(negedge clk);
        check("acq_cnt_d", cnt_d, 2);
        window(8, 0, 0);
        check("t1_upd", upd, 1);
        check("t1_nb", nb_p, 2);
        check("t1_dir", dir, 1);
        check("t1_cnt_d", cnt_d, 2);
        @(negedge clk);
        check("t1_upd_pulse", upd, 0);

        // 3: threshold boundaries
        window(4, 3, 1);
        check("th_4_3_nb", nb_p, 2);
        check("th_4_3_upd", upd, 0);
        window(5, 3, 0);
        check("th_5_3_nb", nb_p, 4);
        check("th_5_3_upd", upd, 1);
        window(0, 0, 8);
        check("th_noT_nb", nb_p, 4);
        window(3, 5, 0);
        check("th_3_5_nb", nb_p, 2);
        window(0, 8, 0);
        check("acq_dec_nb", nb_p, 0);
        window(0, 8, 0);
        check("wrap_0m2_nb", nb_p, 48);

        // 4: lock after 16 quiet windows
        repeat (15) window(4, 4, 0);
        check("lock15_lock", lock, 0);
        check("lock15_cnt_d", cnt_d, 2);
        window(4, 4, 0);
        check("lock16_lock", lock, 1);
        check("lock16_cnt_d", cnt_d, 1);

        // 2/4: track steps of 1 with wrap; reversals keep lock
        for (int i = 0; i < 11; i++) begin
            corr(trk_dir[i]);
            check("trk_nb", nb_p, trk_nb[i]);
            check("trk_lock", lock, 1);
        end
        for (int i = 0; i < 3; i++) begin
            corr(0);
            check("dn_nb", nb_p, dn_nb[i]);
            check("dn_lock", lock, 1);
        end
        corr(0);
        check("unlock_nb", nb_p, 49);
        check("unlock_lock", lock, 0);
        check("unlock_cnt_d", cnt_d, 2);
        window(8, 0, 0);
        check("wrap_49p2_nb", nb_p, 1);
        check("wrap_49p2_dir", dir, 1);

        // 5: disable mid-window
        for (int i = 0; i < 5; i++) begin @(negedge clk); stb = 1; t = 1; e = 0; end
        @(negedge clk); en = 0; stb = 1; t = 1; e = 0;
        @(negedge clk); stb = 0; t = 0;
        check("dis_cnt_d", cnt_d, 0);
        check("dis_upd", upd, 0);
        check("dis_nb", nb_p, 1);
        @(negedge clk); en = 1;
        @(negedge clk);
        check("reen_cnt_d", cnt_d, 2);
        for (int i = 0; i < 3; i++) begin @(negedge clk); stb = 1; t = 1; e = 0; end
        @(negedge clk); stb = 0;
        check("reen_partial_nb", nb_p, 1);
        window(5, 0, 0);
        check("reen_nb", nb_p, 3);
        check("reen_upd", upd, 1);

        // 6: reset on the closing strobe in TRACK
        repeat (16) window(4, 4, 0);
        check("t6_lock", lock, 1);
        for (int i = 0; i < 7; i++) begin @(negedge clk); stb = 1; t = 1; e = 0; end
        @(negedge clk); stb = 1; t = 1; e = 0; rst = 0;
        @(negedge clk); stb = 0; t = 0;
        check("t6_nb", nb_p, 0);
        check("t6_upd", upd, 0);
        check("t6_cnt_d", cnt_d, 0);
        check("t6_lock", lock, 0);
        check("t6_dir", dir, 0);
        rst = 1;
        repeat (3) @(negedge clk);
        check("t6_after_upd", upd, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdr_phase_ctrl.md
Name: cdr_phase_ctrl

Overview:
Loop controller for the CDR phase detector. It collects the detector's Transition/Early decisions over fixed vote windows and filters them by majority. It then steers the detector's phase-select index (nb_P) and delay setting (cnt_d). An ACQUIRE/TRACK state machine declares lock once the phase stops moving.

Parameters:
NB_PHASES, 50, number of phase positions per bit; nb_P ranges 0..NB_PHASES-1 and wraps.
NB_P_INIT, 0, phase index loaded on reset.
VOTE_WIN, 8, phase detector strobes per vote window (2..15).
VOTE_TH, 2, minimum |late-early| needed to move the phase.
LOCK_WIN, 16, consecutive windows with no correction needed to enter TRACK.
UNLOCK_WIN, 4, consecutive same-direction corrections in TRACK that force a return to ACQUIRE.

Ports:
i_clk  in  1  work clock, 50 MHz
i_rst  in  1  reset, synchronous, active-low
i_en  in  1  loop enable; 0 forces IDLE
i_pd_stb  in  1  one-cycle strobe: i_T/i_E are newly valid
i_T  in  1  transition seen (phase detector o_T)
i_E  in  1  early flag (phase detector o_E)
o_nb_P  out  6  phase select to the phase detector
o_cnt_d  out  2  delay setting to the phase detector
o_upd  out  1  one-cycle pulse when o_nb_P changes
o_dir  out  1  direction of the last update (1 = increment)
o_lock  out  1  high in TRACK

Behaviour:
- Reset (i_rst=0 at the clock edge), which overrides everything else:
  - state=IDLE, o_nb_P=NB_P_INIT, o_cnt_d=0, o_upd=0, o_dir=0, o_lock=0.
  - All counters cleared.
- Votes are counted only on cycles with i_pd_stb=1 and state != IDLE:
  - i_T=1, i_E=1 -> early vote.
  - i_T=1, i_E=0 -> late vote.
  - i_T=0 -> no vote, but the strobe still counts toward the window.
- The window closes on the VOTE_WIN-th strobe.
  - That strobe's vote is included in the decision the same cycle.
  - d = late - early, signed, 5 bits.
  - d >= VOTE_TH -> increment by step; d <= -VOTE_TH -> decrement by step; otherwise hold.
  - Vote and strobe counters clear on the closing cycle.
- Step size: 2 in ACQUIRE, 1 in TRACK.
- Phase update arithmetic is modulo NB_PHASES: 49+2 -> 1, 0-1 -> 49, 0-2 -> 48 (default NB_PHASES).
- Update latency: o_nb_P, o_dir and o_upd change on the clock edge after the closing strobe cycle. o_upd is high for exactly 1 cycle.
- o_cnt_d by state: IDLE=0, ACQUIRE=2, TRACK=1. It is registered and changes on the same edge as the state.
- States and transitions:
  - IDLE: on i_en=1 -> ACQUIRE with window, lock and unlock counters cleared.
  - ACQUIRE: a hold window increments the quiet counter; a correction clears it. When the quiet counter reaches LOCK_WIN -> TRACK.
  - TRACK: a correction in the same direction as the previous one increments the unlock counter. A hold or a direction reversal sets it to 0. When it reaches UNLOCK_WIN -> ACQUIRE and the quiet counter clears. The correction that triggers the exit is still applied with step 1.
  - Any state with i_en=0 -> IDLE next edge:
    - o_nb_P is retained.
    - Counters are cleared.
    - A partial window is discarded, with no update.
    - i_pd_stb is ignored in the same cycle.
- Strobes arriving while a decision is being registered are counted into the new window. No strobe is lost.
- Back-to-back strobes on every cycle are legal.

Decomposition:
- Package cdr_pkg holds:
  - the state enum (ST_IDLE, ST_ACQ, ST_TRACK);
  - the cnt_d encodings (CNT_D_IDLE=0, CNT_D_TRACK=1, CNT_D_ACQ=2);
  - the step constants.
- One sub-module, vote_window: strobe and vote counters plus the threshold compare. It outputs a decision-valid pulse and up/down flags.
- The phase arithmetic and the FSM live in the top module.

Test Plan:
1. Reset with i_en=1 and strobes toggling -> outputs hold their reset values (nb_P=0, cnt_d=0, lock=0). Release with 8 strobes of T=1,E=0 -> nb_P=2, o_upd pulse 1 cycle after the 8th strobe, dir=1, cnt_d=2.
2. Wrap: from nb_P=49 in ACQUIRE, one late window -> nb_P=1. From nb_P=0 in TRACK, one early window -> nb_P=49.
3. Threshold: window with 4 late and 3 early -> no update. Window with 5 late and 3 early -> update. Window of 8 strobes with T=0 -> no update.
4. Lock: 16 consecutive balanced windows -> o_lock=1 and cnt_d=1 on the edge after the 16th window closes. Then 4 same-direction corrections -> o_lock=0 and cnt_d=2. With alternating directions, lock is held indefinitely.
5. i_en dropped after 5 strobes of a late window -> IDLE next edge, no o_upd, nb_P unchanged. Re-enable plus 8 late strobes -> exactly one update.
6. Synchronous reset asserted in TRACK between window close and update -> no update appears; all outputs take reset values on that edge.
